e_door_ctrl: RTL

- Parametrised elevator door controller and animator for the Elevator2 display path.
- Accepts open and close requests plus an obstruction sensor, and steps the door position at a programmable rate.
- Holds the door open for a dwell time, then auto-closes. Reverses on obstruction.
- Drives a thermometer-coded door bar (all-ones = closed, all-zeros = open) and status flags to the car controller.

---
 rtl/e_door_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/e_door_ctrl.sv
// e_door_ctrl: elevator door controller and thermometer-bar animator.
// Define E_DOOR_NUDGE_EN to add nudge-mode closing after repeated obstructions.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   open_req            level open request (beats close_req)
//   close_req           level early-close request
//   obstruct            door-path obstruction sensor
//   door[SEGS]          thermometer bar, MSB fills first, all-ones = closed
//   pos[PW]             closed segment count, 0..SEGS
//   is_open/is_closed   registered state flags
//   moving              OPENING or CLOSING
//   done                one-cycle pulse on OPEN/CLOSED entry
//   nudge               nudge-mode close in progress
module e_door_ctrl #(
  parameter int SEGS       = 4,
  parameter int STEP_DIV   = 1,
  parameter int DWELL      = 8,
  parameter int REOPEN_MAX = 3,
  localparam int PW        = $clog2(SEGS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          open_req,
  input  logic          close_req,
  input  logic          obstruct,
  output logic [SEGS-1:0] door,
  output logic [PW-1:0] pos,
  output logic          is_open,
  output logic          is_closed,
  output logic          moving,
  output logic          done,
  output logic          nudge
);

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  // Prescaler is wide enough for the doubled nudge period.
  localparam int PSW = $clog2(2 * STEP_DIV);
  localparam int DW  = $clog2(DWELL + 1);

  localparam logic [PW-1:0]  POS_FULL = PW'(SEGS);
  localparam logic [PW-1:0]  POS_PEN  = PW'(SEGS - 1);
  localparam logic [PW-1:0]  POS_ONE  = PW'(1);
  localparam logic [DW-1:0]  DWELL_V  = DW'(DWELL);
  localparam logic [DW-1:0]  DW_ONE   = DW'(1);
  localparam logic [PSW-1:0] LIM_N    = PSW'(STEP_DIV - 1);
  localparam logic [PSW-1:0] PS_ONE   = PSW'(1);

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           is_open_q, is_closed_q;
  logic           moving_q, done_q;

  logic [PSW-1:0] tick_lim;
  logic           tick;
  logic           obs_eff;
  logic           enter;

`ifdef E_DOOR_NUDGE_EN
  localparam int RW = (REOPEN_MAX < 1) ? 1 : $clog2(REOPEN_MAX + 1);
  localparam logic [RW-1:0]  RMAX  = RW'(REOPEN_MAX);
  localparam logic [RW-1:0]  R_ONE = RW'(1);
  localparam logic [PSW-1:0] LIM_S = PSW'(2 * STEP_DIV - 1);

  logic          nudge_q, nudge_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // Nudge halves the step rate and makes the door deaf to obstruct.
  assign tick_lim = nudge_q ? LIM_S : LIM_N;
  assign obs_eff  = obstruct & ~nudge_q;
  assign nudge    = nudge_q;
`else
  logic unused_reopen;

  assign tick_lim      = LIM_N;
  assign obs_eff       = obstruct;
  assign nudge         = 1'b0;
  assign unused_reopen = |REOPEN_MAX;
`endif

  assign tick  = (presc_q == tick_lim);
  assign enter = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dwell_d = dwell_q;
    presc_d = presc_q;
    unique case (state_q)
      ST_CLOSED: begin
        if (open_req) state_d = ST_OPENING;
      end
      ST_OPENING: begin
        if (tick) begin
          if (pos_q <= POS_ONE) begin
            pos_d   = '0;
            state_d = ST_OPEN;
            dwell_d = DWELL_V;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
      end
      ST_OPEN: begin
        if (open_req || obs_eff) begin
          dwell_d = DWELL_V;
        end else if (close_req) begin
          state_d = ST_CLOSING;
        end else if (tick) begin
          if (dwell_q <= DW_ONE) state_d = ST_CLOSING;
          else dwell_d = dwell_q - DW_ONE;
        end
      end
      ST_CLOSING: begin
        // A reversal beats the step, even on the arrival tick.
        if (open_req || obs_eff) begin
          state_d = ST_OPENING;
        end else if (tick) begin
          if (pos_q >= POS_PEN) begin
            pos_d   = POS_FULL;
            state_d = ST_CLOSED;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end
      end
      default: begin
        state_d = ST_CLOSED;
        pos_d   = POS_FULL;
      end
    endcase
    if (enter && state_d == ST_CLOSED) dwell_d = '0;
    // Every state entry restarts the step period.
    if (enter) presc_d = '0;
    else if (state_q != ST_CLOSED) presc_d = tick ? '0 : presc_q + PS_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLOSED;
      pos_q       <= POS_FULL;
      presc_q     <= '0;
      dwell_q     <= '0;
      is_open_q   <= 1'b0;
      is_closed_q <= 1'b1;
      moving_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      dwell_q     <= dwell_d;
      is_open_q   <= (state_d == ST_OPEN);
      is_closed_q <= (state_d == ST_CLOSED);
      moving_q    <= (state_d == ST_OPENING) ||
                     (state_d == ST_CLOSING);
      done_q      <= enter &&
                     ((state_d == ST_OPEN) ||
                      (state_d == ST_CLOSED));
    end
  end

`ifdef E_DOOR_NUDGE_EN
  always_comb begin
    nudge_d = nudge_q;
    rcnt_d  = rcnt_q;
    // In CLOSING an effective obstruct always reverses the door.
    if (state_q == ST_CLOSING && obs_eff && rcnt_q != RMAX)
      rcnt_d = rcnt_q + R_ONE;
    if (enter && state_d == ST_CLOSING && rcnt_q >= RMAX)
      nudge_d = 1'b1;
    if (enter && state_d == ST_CLOSED) begin
      nudge_d = 1'b0;
      rcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nudge_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      nudge_q <= nudge_d;
      rcnt_q  <= rcnt_d;
    end
  end
`endif

  always_comb begin
    door = '0;
    for (int i = 0; i < SEGS; i++)
      door[SEGS-1-i] = (i < int'(pos_q));
  end

  assign pos       = pos_q;
  assign is_open   = is_open_q;
  assign is_closed = is_closed_q;
  assign moving    = moving_q;
  assign done      = done_q;

endmodule
